// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and sizing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 9600;

  // Rounded to nearest so the bit period error stays under half a clock.
  localparam int DEFAULT_CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - character handshake and serial line between upstream FSM and transmitter.
interface uart_tx_if #(
  parameter int N = 8
);

  logic         enable;
  logic [N-1:0] bus;
  logic         busy;
  logic         tx;

  modport master (
    output enable,
    output bus,
    input  busy,
    input  tx
  );

  modport slave (
    input  enable,
    input  bus,
    output busy,
    output tx
  );

endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, pulses tick on the last cycle of each cell.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter, LSB first, busy held for the whole frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx_if
);

  localparam int IW = cnt_width(N);
  localparam logic [IW-1:0] LAST_BIT = IW'(N - 1);

  uart_state_t   r_state;
  uart_state_t   w_state_next;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  w_shift_next;
  logic [IW-1:0] r_bit_idx;
  logic [IW-1:0] w_bit_idx_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          r_busy;
  logic          w_busy_next;
  logic          w_tick;
  logic          w_clear;

  // Holding the counter cleared in IDLE aligns every cell to the acceptance edge.
  assign w_clear = (r_state == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    w_busy_next    = r_busy;

    case (r_state)
      IDLE: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (tx_if.enable) begin
          w_shift_next = tx_if.bus;
          w_state_next = START;
          w_busy_next  = 1'b1;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
          w_tx_next      = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            // Next bit is shift[1] now, which becomes shift[0] after this shift.
            w_shift_next   = r_shift >> 1;
            w_bit_idx_next = r_bit_idx + IW'(1);
            w_tx_next      = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_tx_next    = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign tx_if.busy = r_busy;
  assign tx_if.tx   = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx with CLKS_PER_BIT=4.
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  uart_tx_if #(.N(8)) u_if ();

  uart_tx #(
    .N           (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tx_if(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    u_if.bus    = d;
    u_if.enable = 1'b1;
  endtask

  // Cell j of exp is bit j: bit 0 start, bits 1..8 data LSB first, bit 9 stop.
  task automatic run_frame(input logic [9:0] exp, input string tag, input bit drop_enable);
    int   busy_cnt;
    logic bad;
    logic got;
    busy_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      bad = 1'b0;
      got = exp[j];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (j == 0 && c == 0 && drop_enable) u_if.enable = 1'b0;
        if (u_if.busy === 1'b1) busy_cnt++;
        if (u_if.tx !== exp[j] && !bad) begin
          bad = 1'b1;
          got = u_if.tx;
        end
      end
      check($sformatf("%s cell%0d tx", tag, j), 32'(got), 32'(exp[j]));
    end
    @(negedge clk);
    check($sformatf("%s busy cycles", tag), busy_cnt, 10 * CPB);
    check($sformatf("%s end busy", tag), 32'(u_if.busy), 0);
    check($sformatf("%s end tx", tag), 32'(u_if.tx), 1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0) bad++;
    end
    check($sformatf("%s idle cycles disturbed", tag), bad, 0);
  endtask

  vec_t  vecs[8];
  string msg;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    u_if.enable = 1'b0;
    u_if.bus    = 8'h00;

    vecs[0] = '{8'h57, 10'b1_0101_0111_0};
    vecs[1] = '{8'h61, 10'b1_0110_0001_0};
    vecs[2] = '{8'h00, 10'b1_0000_0000_0};
    vecs[3] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[4] = '{8'hAA, 10'b1_1010_1010_0};
    vecs[5] = '{8'h2E, 10'b1_0010_1110_0};
    vecs[6] = '{8'h01, 10'b1_0000_0001_0};
    vecs[7] = '{8'h80, 10'b1_1000_0000_0};

    repeat (2) @(negedge clk);
    check("reset tx", 32'(u_if.tx), 1);
    check("reset busy", 32'(u_if.busy), 0);
    reset = 1'b0;
    check_idle("post reset", 3);

    for (int v = 0; v < 8; v++) begin
      start_frame(vecs[v].data);
      run_frame(vecs[v].exp, $sformatf("vec%0d_%02h", v, vecs[v].data), 1'b1);
    end

    // Enable pulses while busy must be ignored and mid-frame bus changes must not leak.
    start_frame(8'h61);
    fork
      run_frame(10'b1_0110_0001_0, "busy_en", 1'b1);
      begin
        repeat (5) @(negedge clk);
        u_if.enable = 1'b1;
        u_if.bus    = 8'hFF;
        @(negedge clk);
        u_if.enable = 1'b0;
        repeat (14) @(negedge clk);
        u_if.enable = 1'b1;
        @(negedge clk);
        u_if.enable = 1'b0;
      end
    join
    check_idle("busy_en no second frame", 12);

    // Held enable: exactly one idle-high cycle, then the next frame.
    start_frame(8'h00);
    fork
      run_frame(10'b1_0000_0000_0, "b2b_first", 1'b0);
      begin
        repeat (20) @(negedge clk);
        u_if.bus = 8'hFF;
      end
    join
    run_frame(10'b1_1111_1111_0, "b2b_second", 1'b1);
    check_idle("b2b tail", 4);

    // Reset during a start bit: tx must rise before the next edge.
    start_frame(8'h00);
    @(negedge clk);
    u_if.enable = 1'b0;
    @(negedge clk);
    check("rst_start pre tx", 32'(u_if.tx), 0);
    #2 reset = 1'b1;
    #1;
    check("rst_start async tx", 32'(u_if.tx), 1);
    check("rst_start async busy", 32'(u_if.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_start after", 3);

    // Reset during data bit 3 of 0xAA.
    start_frame(8'hAA);
    @(negedge clk);
    u_if.enable = 1'b0;
    repeat (17) @(negedge clk);
    check("rst_data pre busy", 32'(u_if.busy), 1);
    check("rst_data pre tx", 32'(u_if.tx), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_data async tx", 32'(u_if.tx), 1);
    check("rst_data async busy", 32'(u_if.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_data after", 6);
    start_frame(8'h2E);
    run_frame(10'b1_0010_1110_0, "rst_recover", 1'b1);

    // Full message through an upstream-style driver with an independent line decoder.
    msg = "Wake up, Neo...";
    fork
      begin
        int cnt;
        @(negedge clk);
        u_if.bus    = msg[0];
        u_if.enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
          @(negedge clk);
          u_if.enable = 1'b0;
          check($sformatf("msg accept %0d", i), 32'(u_if.busy), 1);
          cnt = 0;
          do begin
            @(negedge clk);
            cnt++;
          end while (u_if.busy === 1'b1 && cnt < 100);
          check($sformatf("msg busy len %0d", i), cnt, 10 * CPB);
          if (i < 14) begin
            u_if.bus    = msg[i+1];
            u_if.enable = 1'b1;
          end
        end
      end
      begin
        int         w;
        logic [7:0] got;
        for (int i = 0; i < 15; i++) begin
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (u_if.tx !== 1'b0 && w < 200);
          check($sformatf("msg start bit %0d", i), 32'(u_if.tx), 0);
          repeat (CPB + CPB / 2) @(negedge clk);
          got[0] = u_if.tx;
          for (int b = 1; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            got[b] = u_if.tx;
          end
          repeat (CPB) @(negedge clk);
          check($sformatf("msg stop bit %0d", i), 32'(u_if.tx), 1);
          check($sformatf("msg char %0d", i), 32'(got), 32'(msg[i]));
        end
      end
    join
    check_idle("msg tail", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
